// File: rtl/fb_write_ctrl.sv
// rtl/fb_write_ctrl.sv - framebuffer write-port arbiter: clear engine plus 2-stage pixel-draw pipeline
// Optional macro FB_VBLANK_WR_EN: draws are only accepted while vbl is high.
module fb_write_ctrl #(
  parameter int CORDW     = 16,
  parameter int CIDXW     = 4,
  parameter int FB_WIDTH  = 160,
  parameter int FB_HEIGHT = 120,
  parameter int FB_PIXELS = FB_WIDTH * FB_HEIGHT,
  parameter int FB_ADDRW  = $clog2(FB_PIXELS)
) (
  input  logic                clk_pix,
  input  logic                rst_pix,
  input  logic                vbl,
  input  logic                clr_req,
  input  logic [CIDXW-1:0]    clr_colr,
  output logic                clr_busy,
  output logic                clr_done,
  input  logic                pix_valid,
  output logic                pix_ready,
  input  logic [CORDW-1:0]    pix_x,
  input  logic [CORDW-1:0]    pix_y,
  input  logic [CIDXW-1:0]    pix_colr,
  output logic                we,
  output logic [FB_ADDRW-1:0] addr_write,
  output logic [CIDXW-1:0]    data_in
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DRAIN = 2'd1;
  localparam logic [1:0] CLEAR = 2'd2;

  localparam logic [FB_ADDRW-1:0]     LAST_ADDR = FB_ADDRW'(FB_PIXELS - 1);
  localparam logic [FB_ADDRW-1:0]     WIDTH_A   = FB_ADDRW'(FB_WIDTH);
  localparam logic signed [CORDW-1:0] WIDTH_S   = CORDW'(FB_WIDTH);
  localparam logic signed [CORDW-1:0] HEIGHT_S  = CORDW'(FB_HEIGHT);

  logic [1:0]          state_q, state_d;
  logic                drn_q, drn_d;
  logic [FB_ADDRW-1:0] cnt_q, cnt_d;
  logic [CIDXW-1:0]    clr_colr_q, clr_colr_d;
  logic                clr_done_q, clr_done_d;

  logic                s1_vld_q, s1_vld_d;
  logic                s1_inr_q, s1_inr_d;
  logic [FB_ADDRW-1:0] s1_x_q, s1_x_d;
  logic [FB_ADDRW-1:0] s1_prod_q, s1_prod_d;
  logic [CIDXW-1:0]    s1_colr_q, s1_colr_d;

  logic                we_q, we_d;
  logic [FB_ADDRW-1:0] addr_q, addr_d;
  logic [CIDXW-1:0]    data_q, data_d;

  logic                clr_wr;
  logic [FB_ADDRW-1:0] clr_addr;

`ifdef FB_VBLANK_WR_EN
  assign pix_ready = !rst_pix && (state_q == IDLE) && !clr_req && vbl;
`else
  logic unused_vbl;
  assign unused_vbl = vbl;
  assign pix_ready  = !rst_pix && (state_q == IDLE) && !clr_req;
`endif

  always_comb begin
    state_d    = state_q;
    drn_d      = drn_q;
    cnt_d      = cnt_q;
    clr_colr_d = clr_colr_q;
    clr_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d    = DRAIN;
          drn_d      = 1'b0;
          clr_colr_d = clr_colr;
        end
      end
      DRAIN: begin
        drn_d = 1'b1;
        if (drn_q) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        if (cnt_q == LAST_ADDR) begin
          state_d    = IDLE;
          cnt_d      = '0;
          clr_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output registers lead the CLEAR counter by one cycle so address k lands while cnt_q == k.
  assign clr_wr   = ((state_q == DRAIN) && drn_q) || ((state_q == CLEAR) && (cnt_q != LAST_ADDR));
  assign clr_addr = (state_q == CLEAR) ? cnt_q + 1'b1 : '0;

  always_comb begin
    s1_vld_d  = pix_valid && pix_ready;
    s1_inr_d  = !pix_x[CORDW-1] && ($signed(pix_x) < WIDTH_S) &&
                !pix_y[CORDW-1] && ($signed(pix_y) < HEIGHT_S);
    s1_x_d    = pix_x[FB_ADDRW-1:0];
    s1_prod_d = pix_y[FB_ADDRW-1:0] * WIDTH_A;
    s1_colr_d = pix_colr;
  end

  always_comb begin
    we_d   = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    if (clr_wr) begin
      we_d   = 1'b1;
      addr_d = clr_addr;
      data_d = clr_colr_q;
    end else if (s1_vld_q && s1_inr_q) begin
      we_d   = 1'b1;
      addr_d = s1_prod_q + s1_x_q;
      data_d = s1_colr_q;
    end
  end

  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      state_q    <= IDLE;
      drn_q      <= 1'b0;
      cnt_q      <= '0;
      clr_colr_q <= '0;
      clr_done_q <= 1'b0;
      s1_vld_q   <= 1'b0;
      s1_inr_q   <= 1'b0;
      s1_x_q     <= '0;
      s1_prod_q  <= '0;
      s1_colr_q  <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      drn_q      <= drn_d;
      cnt_q      <= cnt_d;
      clr_colr_q <= clr_colr_d;
      clr_done_q <= clr_done_d;
      s1_vld_q   <= s1_vld_d;
      s1_inr_q   <= s1_inr_d;
      s1_x_q     <= s1_x_d;
      s1_prod_q  <= s1_prod_d;
      s1_colr_q  <= s1_colr_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
    end
  end

  assign clr_busy   = (state_q != IDLE);
  assign clr_done   = clr_done_q;
  assign we         = we_q;
  assign addr_write = addr_q;
  assign data_in    = data_q;

endmodule

// File: tb/tb_fb_write_ctrl.sv
// tb/tb_fb_write_ctrl.sv - directed-vector bench for fb_write_ctrl
module tb_fb_write_ctrl;
  localparam int CORDW     = 16;
  localparam int CIDXW     = 4;
  localparam int FB_PIXELS = 19200;
  localparam int FB_ADDRW  = 15;

  logic                clk_pix = 1'b0;
  logic                rst_pix;
  logic                vbl;
  logic                clr_req;
  logic [CIDXW-1:0]    clr_colr;
  logic                clr_busy;
  logic                clr_done;
  logic                pix_valid;
  logic                pix_ready;
  logic [CORDW-1:0]    pix_x;
  logic [CORDW-1:0]    pix_y;
  logic [CIDXW-1:0]    pix_colr;
  logic                we;
  logic [FB_ADDRW-1:0] addr_write;
  logic [CIDXW-1:0]    data_in;

  int n_vec = 0;
  int n_err = 0;

  fb_write_ctrl dut (
    .clk_pix    (clk_pix),
    .rst_pix    (rst_pix),
    .vbl        (vbl),
    .clr_req    (clr_req),
    .clr_colr   (clr_colr),
    .clr_busy   (clr_busy),
    .clr_done   (clr_done),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pix_colr   (pix_colr),
    .we         (we),
    .addr_write (addr_write),
    .data_in    (data_in)
  );

  always #5 clk_pix = ~clk_pix;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk_pix);
    #1;
  endtask

  task automatic mid;
    @(negedge clk_pix);
  endtask

  task automatic drive_pix(input logic v, input int x, input int y, input int c);
    pix_valid = v;
    pix_x     = CORDW'(x);
    pix_y     = CORDW'(y);
    pix_colr  = CIDXW'(c);
  endtask

  task automatic check_wr(input string tag, input logic ew, input int ea, input int ed);
    check({tag, "_we"}, 32'(we), 32'(ew));
    check({tag, "_addr"}, 32'(addr_write), 32'(ea));
    check({tag, "_data"}, 32'(data_in), 32'(ed));
  endtask

  int bx[4] = '{0, 159, 160, -1};
  int by[4] = '{0, 119, 0, 5};
  int bc[4] = '{1, 2, 4, 5};
  logic be[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
  int ba[4] = '{0, 19199, 19199, 19199};
  int bd[4] = '{1, 2, 2, 2};

  initial begin
    int addr_bad;
    int data_bad;
    int ctrl_bad;

    rst_pix  = 1'b1;
    vbl      = 1'b1;
    clr_req  = 1'b0;
    clr_colr = '0;
    drive_pix(1'b0, 0, 0, 0);

    // reset state
    cyc; cyc;
    mid;
    check_wr("rst", 1'b0, 0, 0);
    check("rst_busy", 32'(clr_busy), 0);
    check("rst_done", 32'(clr_done), 0);
    check("rst_ready", 32'(pix_ready), 0);

    // single draw (5,2,7) -> addr 325 at A+2
    cyc; rst_pix = 1'b0;
    drive_pix(1'b1, 5, 2, 7);
    mid; check("d1_ready", 32'(pix_ready), 1);
    cyc; drive_pix(1'b0, 0, 0, 0);
    mid; check("d1_a1_we", 32'(we), 0);
    cyc; mid; check_wr("d1_a2", 1'b1, 325, 7);
    cyc; mid; check_wr("d1_a3", 1'b0, 325, 7);

    // back-to-back draws, two off-screen
    for (int i = 0; i < 6; i++) begin
      cyc;
      if (i < 4) drive_pix(1'b1, bx[i], by[i], bc[i]);
      else drive_pix(1'b0, 0, 0, 0);
      mid;
      if (i < 4) check($sformatf("b2b_ready%0d", i), 32'(pix_ready), 1);
      if (i >= 2) check_wr($sformatf("b2b%0d", i - 2), be[i-2], ba[i-2], bd[i-2]);
    end

    // T-1: draw (3,0,6); T: clr_req colr 3 with a held draw (10,1,12)
    cyc; drive_pix(1'b1, 3, 0, 6);
    mid; check("clr_tm1_ready", 32'(pix_ready), 1);
    cyc; drive_pix(1'b1, 10, 1, 12); clr_req = 1'b1; clr_colr = 4'd3;
    mid;
    check("clr_t_ready", 32'(pix_ready), 0);
    check("clr_t_we", 32'(we), 0);
    cyc; clr_req = 1'b0; clr_colr = 4'd0;
    mid;
    check_wr("clr_t1_draw", 1'b1, 3, 6);
    check("clr_t1_busy", 32'(clr_busy), 1);
    check("clr_t1_ready", 32'(pix_ready), 0);
    cyc; mid;
    check("clr_t2_we", 32'(we), 0);
    check("clr_t2_busy", 32'(clr_busy), 1);
    check("clr_t2_ready", 32'(pix_ready), 0);

    addr_bad = 0;
    data_bad = 0;
    ctrl_bad = 0;
    for (int k = 0; k < FB_PIXELS; k++) begin
      cyc;
      // ignored re-request in the middle of the clear
      clr_req  = (k == 5000);
      clr_colr = (k == 5000) ? 4'd9 : 4'd0;
      mid;
      if (we !== 1'b1 || addr_write !== FB_ADDRW'(k)) addr_bad++;
      if (data_in !== 4'd3) data_bad++;
      if (pix_ready !== 1'b0 || clr_busy !== 1'b1 || clr_done !== 1'b0) ctrl_bad++;
    end
    check("clr_addr_bad", 32'(addr_bad), 0);
    check("clr_data_bad", 32'(data_bad), 0);
    check("clr_ctrl_bad", 32'(ctrl_bad), 0);

    cyc; clr_req = 1'b0;
    mid;
    check("clr_end_done", 32'(clr_done), 1);
    check("clr_end_busy", 32'(clr_busy), 0);
    check("clr_end_we", 32'(we), 0);
    check("clr_end_ready", 32'(pix_ready), 1);
    cyc; drive_pix(1'b0, 0, 0, 0);
    mid;
    check("clr_end1_done", 32'(clr_done), 0);
    check("clr_end1_we", 32'(we), 0);
    check("clr_end1_busy", 32'(clr_busy), 0);
    cyc; mid;
    check_wr("held_draw", 1'b1, 170, 12);
    check("clr_end2_done", 32'(clr_done), 0);

    // reset while clear writes address 100
    cyc; clr_req = 1'b1; clr_colr = 4'd5;
    cyc; clr_req = 1'b0;
    cyc;
    for (int k = 0; k <= 100; k++) cyc;
    mid;
    check_wr("rc_a100", 1'b1, 100, 5);
    cyc; rst_pix = 1'b1;
    mid; check("rc_rst_ready", 32'(pix_ready), 0);
    cyc; rst_pix = 1'b0;
    mid;
    check("rc_we", 32'(we), 0);
    check("rc_busy", 32'(clr_busy), 0);
    check("rc_done", 32'(clr_done), 0);
    check("rc_ready", 32'(pix_ready), 1);
    for (int k = 0; k < 4; k++) begin
      cyc; mid;
      check($sformatf("rc_idle_done%0d", k), 32'(clr_done), 0);
      check($sformatf("rc_idle_we%0d", k), 32'(we), 0);
    end

`ifdef FB_VBLANK_WR_EN
    // draws stall while vbl is low
    cyc; vbl = 1'b0; drive_pix(1'b1, 1, 1, 8);
    for (int k = 0; k < 3; k++) begin
      mid; check($sformatf("vbl_low_ready%0d", k), 32'(pix_ready), 0);
      cyc;
    end
    vbl = 1'b1;
    mid; check("vbl_v_ready", 32'(pix_ready), 1);
    cyc; drive_pix(1'b0, 0, 0, 0);
    mid; check("vbl_v1_we", 32'(we), 0);
    cyc; mid; check_wr("vbl_v2", 1'b1, 161, 8);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fb_write_ctrl.md
# fb_write_ctrl

Write-side controller for the 4-bit indexed framebuffer `bram_sdp` (160x120, colour index per pixel). It shares the single BRAM write port between two requesters: an internal clear engine that fills the whole buffer with one colour index, and an external pixel-draw stream using a valid/ready handshake. The block converts signed (x,y) coordinates to a linear address and drops off-screen pixels. It sits beside the display read path in `clk_pix` and drives `we`/`addr_write`/`data_in` of the framebuffer BRAM.

## Interface
- `CORDW`, 16, signed coordinate width (bits)
- `CIDXW`, 4, colour index width, equal to BRAM data width
- `FB_WIDTH`, 160, framebuffer width (pixels)
- `FB_HEIGHT`, 120, framebuffer height (pixels)
- `FB_PIXELS`, FB_WIDTH*FB_HEIGHT, total pixels
- `FB_ADDRW`, $clog2(FB_PIXELS), address width

- `clk_pix`  in  1  pixel clock, sole clock
- `rst_pix`  in  1  reset, synchronous, active-high
- `vbl`  in  1  high while display is not reading framebuffer rows (used only with macro)
- `clr_req`  in  1  single-cycle clear request
- `clr_colr`  in  CIDXW  clear colour index, sampled with `clr_req`
- `clr_busy`  out  1  clear sequence in progress
- `clr_done`  out  1  one-cycle pulse, clear finished
- `pix_valid`  in  1  draw request valid
- `pix_ready`  out  1  draw request accepted when valid&&ready
- `pix_x`, `pix_y`  in  CORDW  signed pixel coordinates
- `pix_colr`  in  CIDXW  pixel colour index
- `we`  out  1  BRAM write enable
- `addr_write`  out  FB_ADDRW  BRAM write address
- `data_in`  out  CIDXW  BRAM write data

## Operation
- FSM states: IDLE, DRAIN, CLEAR.
- IDLE: draw port open. `pix_ready` = !rst_pix && state==IDLE && !clr_req (combinational; clear has priority in the same cycle).
- Draw pipeline, 2 stages: S1 registers colour, x, product y*FB_WIDTH, and in-range flag (0<=x<FB_WIDTH && 0<=y<FB_HEIGHT, signed compare); S2 registers we=in-range, addr_write=product+x (FB_ADDRW bits), data_in=colour.
- Out-of-range pixels are accepted (handshake completes) but produce no write.
- `clr_req` in IDLE: latch `clr_colr`, go DRAIN. `clr_req` in DRAIN/CLEAR ignored (no queueing, colour not updated).
- DRAIN: 2 cycles, lets in-flight draws reach BRAM; then CLEAR.
- CLEAR: counter 0..FB_PIXELS-1, one write per cycle, data=latched colour. After last address, return to IDLE with `clr_done` pulse.
- `we` low whenever no write is scheduled; `addr_write`/`data_in` hold last value.
- Reset values: state IDLE, `we`=0, `addr_write`=0, `data_in`=0, `clr_busy`=0, `clr_done`=0, pipeline valids cleared, counter 0. Reset mid-clear aborts; no `clr_done`; partially cleared memory left as is.

## Timing
- Draw: accepted in cycle A -> `we`=1 with its address/data in cycle A+2. Throughput 1 pixel/cycle.
- Clear: `clr_req` in cycle T (IDLE) -> `clr_busy` high T+1 .. T+2+FB_PIXELS; write addr k in cycle T+3+k; last write T+2+FB_PIXELS; `clr_done` high and `clr_busy` low in T+3+FB_PIXELS; `pix_ready` may rise in that same cycle.
- Draws accepted up to T-1 write no later than T+1, never overlapping clear writes.
- `pix_valid` with `clr_req` in same cycle: draw not accepted, requester must hold.
- Address arithmetic unsigned after range check; product fits FB_ADDRW for in-range y.

## Configuration
- `FB_VBLANK_WR_EN` defined: `pix_ready` additionally requires `vbl`=1; clear engine still runs regardless of `vbl`. Prevents tearing from draws during active scan.
- Undefined: `vbl` ignored; draws accepted whenever IDLE.

## Test plan
- Reset then draw (x=5,y=2,colr=7) accepted at A -> `we`=1, `addr_write`=325, `data_in`=7 at A+2; `we`=0 at A+3.
- Back-to-back draws (0,0),(159,119),(160,0),(-1,5) -> writes at addr 0 and 19199 only; ready high all 4 cycles.
- `clr_req` with `clr_colr`=3 at T while draw accepted at T-1 -> draw write at T+1, addr 0..19199 data 3 at T+3..T+19202, `clr_done` at T+19203, `pix_ready` low T..T+19202.
- Second `clr_req` (colr=9) mid-clear -> ignored, all data 3, single `clr_done`.
- `rst_pix` at clear address 100 -> next cycle `we`=0, `clr_busy`=0, no `clr_done`, ready high after reset.
- With `FB_VBLANK_WR_EN`: `pix_valid` held while `vbl`=0 -> `pix_ready`=0; `vbl` rises at V -> accept at V, write at V+2.
